// File: rtl/data_mem_responder_pkg.sv
// Shared state encoding, default sizing and address-checking helper for the
// data memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_LATENCY     = 2;

  // A request is rejected if it is not word aligned or indexes past the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage for the responder: combinational read port, clocked write port.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder for the pipeline memory stage.
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency counter running down
// RESP  | one-cycle response; stores commit on the edge that ends it
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          w_accept;
  logic          w_resp;
  logic          w_err;
  logic          w_we;
  logic [31:0]   w_rdata;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_next = ST_RESP;
          end else begin
            w_next     = ST_WAIT;
            w_cnt_next = CW'(LATENCY - 2);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
    end
  end

  assign w_resp = (r_state == ST_RESP);
  assign w_err  = addr_err(r_addr, DEPTH_WORDS);
  // Gate with rst so a reset landing on the RESP cycle abandons the store.
  assign w_we   = w_resp && r_write && !w_err && rst;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_dmem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_addr[AW+1:2]),
    .i_wdata(r_wdata),
    .i_raddr(r_addr[AW+1:2]),
    .o_rdata(w_rdata)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = w_resp;
  assign resp_err   = w_resp && w_err;
  assign resp_rdata = (w_resp && !w_err && !r_write) ? w_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives three responders (LATENCY 1, 2, 5) with shared stimulus and checks
// every cycle against a transaction-level model of each.
module tb_data_mem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        o_rdy  [NI];
  logic        o_rv   [NI];
  logic [31:0] o_rd   [NI];
  logic        o_err  [NI];
  logic        o_busy [NI];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          lat   [NI];
  int          age   [NI];
  bit          m_wr  [NI];
  logic [31:0] m_addr[NI];
  logic [31:0] m_wd  [NI];
  logic [31:0] mem   [NI][DEPTH];
  bit          known [NI][DEPTH];

  bit          cap_seen;
  logic        cap_err;
  logic [31:0] cap_rd;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(o_rdy[0]),
    .resp_valid(o_rv[0]), .resp_rdata(o_rd[0]), .resp_err(o_err[0]), .busy(o_busy[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(o_rdy[1]),
    .resp_valid(o_rv[1]), .resp_rdata(o_rd[1]), .resp_err(o_err[1]), .busy(o_busy[1]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(5)) u_dut_l5 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(o_rdy[2]),
    .resp_valid(o_rv[2]), .resp_rdata(o_rd[2]), .resp_err(o_err[2]), .busy(o_busy[2]));

  function automatic bit is_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic bit any_busy();
    bit b = 0;
    for (int k = 0; k < NI; k++) if (age[k] != 0) b = 1;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // age = edges since acceptance; the response cycle is age == latency.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        age[k] = 0;
      end else if (age[k] == 0) begin
        if (req_valid) begin
          age[k]    = 1;
          m_wr[k]   = req_write;
          m_addr[k] = req_addr;
          m_wd[k]   = req_wdata;
        end
      end else if (age[k] == lat[k]) begin
        if (m_wr[k] && !is_err(m_addr[k])) begin
          mem[k][m_addr[k] / 4]   = m_wd[k];
          known[k][m_addr[k] / 4] = 1;
        end
        age[k] = 0;
      end else begin
        age[k]++;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < NI; k++) begin
      bit exp_rv = (age[k] == lat[k]);
      bit e      = exp_rv && is_err(m_addr[k]);
      chk($sformatf("i%0d_ready", k), 32'(o_rdy[k]),  32'(age[k] == 0));
      chk($sformatf("i%0d_busy", k),  32'(o_busy[k]), 32'(age[k] != 0));
      chk($sformatf("i%0d_rvalid", k), 32'(o_rv[k]), 32'(exp_rv));
      chk($sformatf("i%0d_rerr", k),  32'(o_err[k]),  32'(e));
      if (!exp_rv || e || m_wr[k])
        chk($sformatf("i%0d_rdata", k), o_rd[k], 32'h0);
      else if (known[k][m_addr[k] / 4])
        chk($sformatf("i%0d_rdata", k), o_rd[k], mem[k][m_addr[k] / 4]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic capture();
    if (o_rv[1] && !cap_seen) begin
      cap_seen = 1;
      cap_err  = o_err[1];
      cap_rd   = o_rd[1];
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (any_busy() && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("idle_timeout", 32'(any_busy()), 32'h0);
  endtask

  // One request while all responders are idle; captures the LATENCY=2 reply.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input bit toggle);
    int n = 0;
    cap_seen = 0;
    cap_err  = 1'bx;
    cap_rd   = 'x;
    drive(1'b1, w, a, d);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    capture();
    while (any_busy() && n < 40) begin
      if (toggle) begin
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom_range(0, 1));
      end
      tick();
      capture();
      n++;
    end
    if (n >= 40) chk("req_timeout", 32'(any_busy()), 32'h0);
    chk("req_resp_seen", 32'(cap_seen), 32'h1);
  endtask

  initial begin
    logic [7:0] rv1_mask, rv0_mask, rdy0_mask;
    logic [31:0] rd_l2_c5, rd_l1_c3;
    lat[0] = 1; lat[1] = 2; lat[2] = 5;
    for (int k = 0; k < NI; k++) begin
      age[k] = 0; m_wr[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    do_req(1'b1, 32'hFFC, 32'hCAFEF00D, 0);
    do_req(1'b1, 32'h20,  32'h11111111, 0);

    // Store then a load held pending: responses at cycles 2 and 5 for LATENCY=2.
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    rv1_mask = '0; rv0_mask = '0; rdy0_mask = '0;
    rd_l2_c5 = 'x; rd_l1_c3 = 'x;
    for (int c = 1; c <= 7; c++) begin
      rv1_mask[c]  = o_rv[1];
      rv0_mask[c]  = o_rv[0];
      rdy0_mask[c] = o_rdy[0];
      if (c == 5) rd_l2_c5 = o_rd[1];
      if (c == 3) rd_l1_c3 = o_rd[0];
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();
    chk("l2_rvalid_cycles", 32'(rv1_mask), 32'h24);
    chk("l2_load_data", rd_l2_c5, 32'hDEADBEEF);
    chk("l1_rvalid_cycles", 32'(rv0_mask), 32'hAA);
    chk("l1_ready_cycles", 32'(rdy0_mask), 32'h54);
    chk("l1_load_data", rd_l1_c3, 32'hDEADBEEF);
    chk("model_mem_10", mem[1][4], 32'hDEADBEEF);

    // Error requests leave storage untouched.
    do_req(1'b1, 32'h13, 32'h1234, 0);
    chk("misaligned_err", 32'(cap_err), 32'h1);
    chk("misaligned_rdata", cap_rd, 32'h0);
    do_req(1'b1, 32'h1000, 32'h55555555, 0);
    chk("range_err", 32'(cap_err), 32'h1);
    chk("range_rdata", cap_rd, 32'h0);
    do_req(1'b0, 32'h10, 32'h0, 0);
    chk("after_err_10", cap_rd, 32'hDEADBEEF);
    do_req(1'b0, 32'hFFC, 32'h0, 0);
    chk("after_err_ffc", cap_rd, 32'hCAFEF00D);
    chk("after_err_ffc_err", 32'(cap_err), 32'h0);

    // Reset during WAIT abandons the store.
    drive(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    tick();
    chk("rst_wait_busy", 32'(o_busy[1]), 32'h1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    chk("rst_ready", 32'(o_rdy[1]), 32'h1);
    chk("rst_no_rvalid", 32'(o_rv[1]), 32'h0);
    tick();
    chk("rst_no_rvalid_after", 32'(o_rv[1]), 32'h0);
    do_req(1'b0, 32'h20, 32'h0, 0);
    chk("rst_old_value", cap_rd, 32'h11111111);

    // Inputs wiggle during WAIT; only the accepted values matter.
    do_req(1'b1, 32'h30, 32'h0BADCAFE, 1);
    do_req(1'b0, 32'h30, 32'h0, 1);
    chk("toggle_load", cap_rd, 32'h0BADCAFE);

    for (int i = 0; i < 600; i++) begin
      int r;
      logic [31:0] a;
      rst = ($urandom_range(0, 99) != 0);
      r = $urandom_range(0, 9);
      if (r < 6)       a = 32'(4 * $urandom_range(0, 15));
      else if (r == 6) a = 32'hFFC;
      else if (r == 7) a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (r == 8) a = 32'(32'h1000 + 4 * $urandom_range(0, 255));
      else             a = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, range 1..15, meaning the cycles from request acceptance to response.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-low (rst==0 at a rising clk edge resets).
REQ-005 The block SHALL have port req_valid  input  1  the pipeline memory stage presents a request.
REQ-006 The block SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 The block SHALL have port req_addr  input  32  byte address (ALUResultM).
REQ-008 The block SHALL have port req_wdata  input  32  store data (WriteDataM).
REQ-009 The block SHALL have port req_ready  output  1  the responder can accept a request this cycle.
REQ-010 The block SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-011 The block SHALL have port resp_rdata  output  32  load data, valid only with resp_valid.
REQ-012 The block SHALL have port resp_err  output  1  the request was misaligned or out of range, valid only with resp_valid.
REQ-013 The block SHALL have port busy  output  1  a transaction is in flight (IDLE not reached); drives pipeline stall logic.

Function
REQ-014 The block SHALL implement the states IDLE, WAIT and RESP.
REQ-015 In IDLE, req_ready=1; in WAIT and RESP, req_ready=0.
REQ-016 A request SHALL be accepted on a rising edge where req_valid&&req_ready; acceptance latches req_write, req_addr and req_wdata.
REQ-017 On acceptance the block SHALL go to RESP if LATENCY==1, else load the counter with LATENCY-2 and go to WAIT.
REQ-018 In WAIT the counter SHALL decrement each cycle; at counter==0 the block SHALL go to RESP next.
REQ-019 A request accepted at edge N SHALL produce resp_valid=1 exactly in the cycle following edge N+LATENCY-1, i.e. LATENCY cycles after acceptance, for exactly one cycle.
REQ-020 From RESP the block SHALL always go to IDLE; back-to-back acceptance is therefore one request per LATENCY+1 cycles.
REQ-021 busy SHALL equal 1 in WAIT and RESP and 0 in IDLE.
REQ-022 The error condition SHALL be latched addr[1:0]!=0 or the word index addr[31:2] >= DEPTH_WORDS.
REQ-023 For an error request, resp_err=1, resp_rdata=0 and no storage word SHALL change.
REQ-024 For a valid load, resp_rdata SHALL equal the word at addr[31:2] as stored at the RESP cycle, with resp_err=0.
REQ-025 For a valid store, the word SHALL be written on the edge ending the RESP cycle, with resp_rdata=0 and resp_err=0.
REQ-026 A load following a store to the same address SHALL return the stored value.
REQ-027 When resp_valid=0, resp_rdata and resp_err SHALL be 0.
REQ-028 req_* inputs SHALL be ignored outside the accepting edge; changes during WAIT/RESP SHALL have no effect.
REQ-029 The counter SHALL be sized to hold LATENCY-2 without wrap; it SHALL never underflow.

Reset
REQ-030 On reset the block SHALL force state=IDLE, counter=0 and the latched request=0, giving req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0 in the following cycle.
REQ-031 Reset during WAIT or RESP SHALL abandon the transaction: no storage write and no resp_valid.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 Reset SHALL take priority over acceptance in the same cycle.

Structure
REQ-034 The state encoding (IDLE/WAIT/RESP) and the default DEPTH_WORDS/LATENCY constants SHALL reside in the shared package.
REQ-035 The storage SHALL be one sub-module, dmem_array, with a combinational read and a synchronous write enable.

Verification
REQ-036 With LATENCY=2, store 0xDEADBEEF to 0x10 at edge 0, then a load from 0x10: resp_valid is seen at cycles 2 and 5, and the load returns 0xDEADBEEF with resp_err=0.
REQ-037 With LATENCY=1, a load from 0x0 after its store: resp_valid appears 1 cycle after acceptance, and req_ready=0 for exactly 1 cycle.
REQ-038 A store of 0x1234 to 0x13 (misaligned) and a store to 0x1000 (DEPTH=1024): resp_err=1 and resp_rdata=0; subsequent loads of 0x10 and 0xFFC are unchanged.
REQ-039 rst=0 asserted in WAIT during a store of 0xA5A5A5A5 to 0x20: no resp_valid, req_ready=1 after reset, and a load of 0x20 returns the old value.
REQ-040 req_addr and req_wdata are toggled every cycle during WAIT: the response reflects only the values latched at acceptance.
